// File: rtl/event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// event_arbiter_pkg
//   Shared definitions for the event arbiter: default flag bit positions,
//   the per-channel counter type encoding and the event class enumeration.
//   The class enumeration uses the same encoding as the counter types, so a
//   class value can directly select its counter.
// -----------------------------------------------------------------------------
package event_arbiter_pkg;

    localparam int SGL_FLAG_OFFSET_DEF = 122;
    localparam int CMD_FLAG_OFFSET_DEF = 115;

    // Counter type select encoding (value 3 on the select reads as 0)
    localparam logic [1:0] CNT_SGL = 2'd0;
    localparam logic [1:0] CNT_TT  = 2'd1;
    localparam logic [1:0] CNT_CMD = 2'd2;
    localparam int         NUM_CNT = 3;

    typedef enum logic [1:0] {
        EV_SGL = CNT_SGL,
        EV_TT  = CNT_TT,
        EV_CMD = CNT_CMD
    } ev_class_e;

    // The singles flag wins over the command flag.
    function automatic ev_class_e classify(input logic sgl_flag, input logic cmd_flag);
        if (sgl_flag)      return EV_SGL;
        else if (cmd_flag) return EV_CMD;
        else               return EV_TT;
    endfunction

endpackage

// File: rtl/event_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with an internal pointer. Grants the lowest requesting
//   index at or cyclically after the pointer. On advance the pointer moves to
//   one past the granted index; otherwise it holds.
//   Ports:
//     clk, rst    clock, asynchronous active-low reset (pointer -> 0)
//     req         per-index request
//     advance     the current grant was consumed this cycle
//     grant       one-hot grant (all zero when nothing requests)
//     grant_idx   binary index of the grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/event_arbiter.sv
// -----------------------------------------------------------------------------
// event_arbiter
//   Merges NCH frontend event streams. Each word is classified by its flag
//   bits: singles and timetag words are data and are merged round-robin into
//   one registered output stream; command words are routed to a per-channel
//   registered command stream (low CMD_LEN bits). Three saturating counters
//   per channel count accepted singles/timetag/command words.
//   Ports:
//     clk, rst              clock, asynchronous active-low reset
//     in_valid/ready/data   per-channel input streams (channel i at i*LENGTH)
//     out_valid/ready/data  merged data stream, out_chan = source channel
//     cmd_valid/ready/data  per-channel command streams (channel i at i*CMD_LEN)
//     cnt_chan, cnt_type    counter select (type 3 reads 0)
//     cnt_load              per-type clear of the selected channel's counters
//     cnt_value             selected counter, combinational
// -----------------------------------------------------------------------------
module event_arbiter
    import event_arbiter_pkg::*;
#(
    parameter int NCH             = 4,
    parameter int LENGTH          = 128,
    parameter int CMD_LEN         = 32,
    parameter int CNT_WIDTH       = 48,
    parameter int SGL_FLAG_OFFSET = SGL_FLAG_OFFSET_DEF,
    parameter int CMD_FLAG_OFFSET = CMD_FLAG_OFFSET_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [NCH*LENGTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LENGTH-1:0]      out_data,
    output logic [$clog2(NCH)-1:0] out_chan,
    output logic [NCH-1:0]         cmd_valid,
    input  logic [NCH-1:0]         cmd_ready,
    output logic [NCH*CMD_LEN-1:0] cmd_data,
    input  logic [$clog2(NCH)-1:0] cnt_chan,
    input  logic [1:0]             cnt_type,
    input  logic [2:0]             cnt_load,
    output logic [CNT_WIDTH-1:0]   cnt_value
);

    localparam int CW = $clog2(NCH);

    logic [NCH-1:0][LENGTH-1:0] word;
    logic [NCH-1:0]             is_cmd, data_req, grant, accept;
    logic [NCH-1:0][2:0]        inc;
    logic [CW-1:0]              grant_idx;
    logic                       free, data_hs;
    logic [LENGTH-1:0]          sel_word;

    logic                               out_valid_q, out_valid_d;
    logic [LENGTH-1:0]                  out_data_q, out_data_d;
    logic [CW-1:0]                      out_chan_q, out_chan_d;
    logic [NCH-1:0]                     cmd_valid_q, cmd_valid_d;
    logic [NCH-1:0][CMD_LEN-1:0]        cmd_data_q, cmd_data_d;
    logic [NCH-1:0][NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign free = ~out_valid_q | out_ready;

    genvar i;
    for (i = 0; i < NCH; i++) begin : g_ch
        ev_class_e cls;
        assign word[i]     = in_data[i*LENGTH +: LENGTH];
        assign cls         = classify(word[i][SGL_FLAG_OFFSET], word[i][CMD_FLAG_OFFSET]);
        assign is_cmd[i]   = (cls == EV_CMD);
        assign data_req[i] = in_valid[i] & ~is_cmd[i];
        // Gated by rst so nothing is accepted while reset is held.
        assign in_ready[i] = rst & (is_cmd[i] ? ~cmd_valid_q[i] : (grant[i] & free));
        assign accept[i]   = in_valid[i] & in_ready[i];
        // Class encoding equals counter index, so a shift picks the counter.
        assign inc[i]      = {2'b00, accept[i]} << cls;
    end

    assign data_hs = |(accept & ~is_cmd);

    rr_arbiter #(.N(NCH)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (data_req),
        .advance   (data_hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_word = '0;
        for (int c = 0; c < NCH; c++) if (grant[c]) sel_word = word[c];
    end

    // Output register: loads only when free, so it holds while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (free) begin
            out_valid_d = data_hs;
            if (data_hs) begin
                out_data_d = sel_word;
                out_chan_d = grant_idx;
            end
        end
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        for (int c = 0; c < NCH; c++) begin
            cmd_valid_d[c] = (cmd_valid_q[c] & ~cmd_ready[c]) | (accept[c] & is_cmd[c]);
            if (accept[c] && is_cmd[c]) cmd_data_d[c] = word[c][CMD_LEN-1:0];
        end
    end

    // Saturating counters; a load overrides a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (inc[c][k] && cnt_q[c][k] != '1) cnt_d[c][k] = cnt_q[c][k] + 1'b1;
                if (cnt_load[k] && cnt_chan == CW'(c)) cnt_d[c][k] = '0;
            end
        end
    end

    always_comb begin
        cnt_value = '0;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NUM_CNT; k++)
                if (cnt_chan == CW'(c) && cnt_type == 2'(k)) cnt_value = cnt_q[c][k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            cmd_valid_q <= '0;
            cmd_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Bench for event_arbiter: NCH=4, 128-bit words, 4-bit counters so
// saturation is reachable. A cycle-level reference model built from the
// arbitration / routing / counting rules plus a data-word scoreboard.
module tb_event_arbiter;
    localparam int N    = 4;
    localparam int L    = 128;
    localparam int CL   = 32;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid, in_ready, cmd_valid, cmd_ready;
    logic [N*L-1:0]   in_data;
    logic             out_valid, out_ready;
    logic [L-1:0]     out_data;
    logic [1:0]       out_chan, cnt_chan, cnt_type;
    logic [N*CL-1:0]  cmd_data;
    logic [2:0]       cnt_load;
    logic [CNTW-1:0]  cnt_value;

    event_arbiter #(.NCH(N), .LENGTH(L), .CMD_LEN(CL), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cnt_chan(cnt_chan), .cnt_type(cnt_type), .cnt_load(cnt_load), .cnt_value(cnt_value)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_ov;
    logic [L-1:0] m_od;
    int          m_oc, m_ptr;
    bit          m_cv[N];
    logic [CL-1:0] m_cd[N];
    int          m_cnt[N][3];
    bit          m_acc[N];
    bit          e_rdy[N];
    bit          e_free;
    int          e_win;
    logic [L-1:0] sb[$];

    bit src_auto[N];
    int src_p[N];
    int src_cls[N];

    function automatic logic [L-1:0] word_of(input int c);
        return in_data[c*L +: L];
    endfunction

    // 0 = singles, 1 = timetag, 2 = command
    function automatic int cls_of(input logic [L-1:0] w);
        if (w[122]) return 0;
        if (w[115]) return 2;
        return 1;
    endfunction

    function automatic logic [L-1:0] mk_word(input int cls);
        logic [L-1:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        w[122] = (cls == 0);
        if (cls == 2) w[115] = 1'b1;
        else if (cls == 1) w[115] = 1'b0;
        return w;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_od = '0; m_oc = 0; m_ptr = 0;
        for (int c = 0; c < N; c++) begin
            m_cv[c] = 0; m_cd[c] = '0; m_acc[c] = 0;
            for (int k = 0; k < 3; k++) m_cnt[c][k] = 0;
        end
    endtask

    task automatic model_comb();
        e_free = !m_ov || out_ready;
        e_win  = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (e_win < 0 && in_valid[c] && cls_of(word_of(c)) != 2) e_win = c;
        end
        for (int c = 0; c < N; c++) begin
            if (!rst) e_rdy[c] = 0;
            else if (cls_of(word_of(c)) == 2) e_rdy[c] = !m_cv[c];
            else e_rdy[c] = (c == e_win) && e_free;
        end
    endtask

    task automatic model_update();
        model_comb();
        if (!rst) begin model_reset(); return; end
        for (int c = 0; c < N; c++) begin
            int k;
            m_acc[c] = in_valid[c] && e_rdy[c];
            k = cls_of(word_of(c));
            if (m_acc[c] && m_cnt[c][k] < CMAX) m_cnt[c][k]++;
            if (m_cv[c] && cmd_ready[c]) m_cv[c] = 0;
            if (m_acc[c] && k == 2) begin
                m_cv[c] = 1;
                m_cd[c] = word_of(c) & {{(L-CL){1'b0}}, {CL{1'b1}}};
            end
        end
        for (int k = 0; k < 3; k++) if (cnt_load[k]) m_cnt[cnt_chan][k] = 0;
        if (e_free) begin
            m_ov = (e_win >= 0);
            if (e_win >= 0) begin
                m_od = word_of(e_win); m_oc = e_win; m_ptr = (e_win + 1) % N;
            end
        end
    endtask

    task automatic src_advance();
        for (int c = 0; c < N; c++) begin
            if (src_auto[c] && (m_acc[c] || !in_valid[c])) begin
                if (int'($urandom_range(99)) < src_p[c]) begin
                    in_valid[c] = 1'b1;
                    in_data[c*L +: L] = mk_word(src_cls[c] < 0 ? int'($urandom_range(2)) : src_cls[c]);
                end else in_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic tick_check();
        int exp_cnt;
        @(negedge clk);
        model_comb();
        for (int c = 0; c < N; c++) chk($sformatf("in_ready%0d", c), in_ready[c], e_rdy[c]);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_chan", out_chan, m_oc);
        end
        for (int c = 0; c < N; c++) begin
            chk($sformatf("cmd_valid%0d", c), cmd_valid[c], m_cv[c]);
            if (m_cv[c]) chk($sformatf("cmd_data%0d", c), cmd_data[c*CL +: CL], m_cd[c]);
        end
        exp_cnt = 0;
        if (cnt_type != 2'd3) exp_cnt = m_cnt[cnt_chan][cnt_type];
        chk("cnt_value", cnt_value, exp_cnt);
        if (out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) chk("sb_order", out_data, sb.pop_front());
        end
        for (int c = 0; c < N; c++)
            if (in_valid[c] && in_ready[c] && cls_of(word_of(c)) != 2) sb.push_back(word_of(c));
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
        model_update();
        src_advance();
    endtask

    task automatic step();
        tick_check();
        tick_edge();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cnt", cnt_value, 0);
    endtask

    task automatic set_src(input int c, input bit auto_en, input int p, input int cls);
        src_auto[c] = auto_en; src_p[c] = p; src_cls[c] = cls;
    endtask

    initial begin
        logic [L-1:0] w, d0;
        int c0;
        rst = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; cmd_ready = '0;
        cnt_chan = '0; cnt_type = '0; cnt_load = '0;
        for (int c = 0; c < N; c++) set_src(c, 0, 0, 1);
        model_reset();
        #2;
        chk_reset_outputs();
        repeat (2) step();
        rst = 1'b1;

        // Command routing on channel 2
        cnt_chan = 2'd2; cnt_type = 2'd2;
        w = mk_word(2); w[122] = 1'b0; w[115] = 1'b1; w[31:0] = 32'hDEADBEEF;
        in_valid[2] = 1'b1; in_data[2*L +: L] = w;
        step();
        in_valid[2] = 1'b0;
        tick_check();
        chk("cmd2_valid", cmd_valid[2], 1'b1);
        chk("cmd2_data", cmd_data[2*CL +: CL], 32'hDEADBEEF);
        chk("cmd2_no_out", out_valid, 1'b0);
        chk("cmd2_cnt", cnt_value, 1);
        tick_edge();
        cmd_ready = '1;

        // Arbitration order, all channels streaming timetag words
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_src(c, 1, 100, 1);
        src_advance();
        tick_check();
        chk("lat0", out_valid, 1'b0);
        tick_edge();
        for (int k = 0; k < 8; k++) begin
            tick_check();
            chk("arb_v", out_valid, 1'b1);
            chk("arb_seq", out_chan, k % N);
            tick_edge();
        end

        // Output stall
        out_ready = 1'b0;
        d0 = '0; c0 = 0;
        for (int k = 0; k < 5; k++) begin
            tick_check();
            if (k == 0) begin d0 = out_data; c0 = int'(out_chan); end
            else chk("stall_data", out_data, d0);
            chk("stall_rdy", in_ready, 4'b0000);
            tick_edge();
        end
        out_ready = 1'b1;
        step();
        tick_check();
        chk("resume_chan", out_chan, (c0 + 1) % N);
        tick_edge();

        // Command back-pressure on channel 1, channel 0 data keeps flowing
        for (int c = 1; c < N; c++) begin set_src(c, 0, 0, 1); in_valid[c] = 1'b0; end
        cmd_ready[1] = 1'b0;
        in_valid[1] = 1'b1; in_data[1*L +: L] = mk_word(2);
        step();
        in_data[1*L +: L] = mk_word(2);
        for (int k = 0; k < 4; k++) begin
            tick_check();
            chk("cmdbp_rdy", in_ready[1], 1'b0);
            chk("cmdbp_v", out_valid, 1'b1);
            chk("cmdbp_ch", out_chan, 0);
            tick_edge();
        end
        cmd_ready[1] = 1'b1;
        step();
        step();
        in_valid[1] = 1'b0;
        step();

        // Counter saturation and load on channel 3
        set_src(0, 0, 0, 1); in_valid[0] = 1'b0;
        set_src(3, 1, 100, 0);
        src_advance();
        cnt_chan = 2'd3; cnt_type = 2'd0; cnt_load = 3'b111;
        step();
        cnt_load = 3'b000;
        repeat (20) step();
        tick_check();
        chk("sat", cnt_value, CMAX);
        tick_edge();
        cnt_load = 3'b001;
        step();
        cnt_load = 3'b000;
        tick_check();
        chk("load_inc", cnt_value, 0);
        tick_edge();

        // Randomized traffic
        for (int c = 0; c < N; c++) set_src(c, 1, 50 + int'($urandom_range(50)), -1);
        for (int k = 0; k < 800; k++) begin
            out_ready = ($urandom_range(99) < 75);
            for (int c = 0; c < N; c++) cmd_ready[c] = ($urandom_range(99) < 60);
            cnt_chan = 2'($urandom_range(3));
            cnt_type = 2'($urandom_range(3));
            cnt_load = ($urandom_range(99) < 5) ? 3'($urandom_range(7)) : 3'b000;
            step();
        end

        // Reset mid-stream, then first grant after release
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        sb.delete();
        cnt_load = '0;
        for (int c = 0; c < N; c++) set_src(c, 0, 0, 1);
        in_valid = 4'b1010;
        in_data[1*L +: L] = mk_word(1);
        in_data[3*L +: L] = mk_word(1);
        step();
        rst = 1'b1;
        tick_check();
        chk("rst_grant", in_ready, 4'b0010);
        tick_edge();
        tick_check();
        chk("rst_first_v", out_valid, 1'b1);
        chk("rst_first_ch", out_chan, 1);
        tick_edge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of frontend channels, 2..16.
REQ-002 Parameter LENGTH, default 128: event word width.
REQ-003 Parameter CMD_LEN, default 32: command word width, taken from the low bits of the event word.
REQ-004 Parameter CNT_WIDTH, default 48: width of each event counter.
REQ-005 Parameter SGL_FLAG_OFFSET, default 122: bit index of the singles flag.
REQ-006 Parameter CMD_FLAG_OFFSET, default 115: bit index of the command flag.
REQ-007 clk  in  1  single clock for all logic (sys_clk domain).
REQ-008 rst  in  1  reset, asynchronous assert, active-low.
REQ-009 in_valid  in  NCH  per-channel event valid.
REQ-010 in_ready  out  NCH  per-channel event ready.
REQ-011 in_data  in  NCH*LENGTH  per-channel event words; channel i occupies bits [i*LENGTH +: LENGTH].
REQ-012 out_valid  out  1  merged data stream valid.
REQ-013 out_ready  in  1  merged data stream ready.
REQ-014 out_data  out  LENGTH  merged data word.
REQ-015 out_chan  out  clog2(NCH)  source channel of out_data.
REQ-016 cmd_valid / cmd_ready  out / in  NCH each  per-channel command stream handshake.
REQ-017 cmd_data  out  NCH*CMD_LEN  per-channel command word.
REQ-018 cnt_chan  in  clog2(NCH)  counter channel select.
REQ-019 cnt_type  in  2  counter type select: 0 = singles, 1 = timetag, 2 = command, 3 = reads 0.
REQ-020 cnt_load  in  3  clears the counters of the selected channel, one bit per type.
REQ-021 cnt_value  out  CNT_WIDTH  selected counter value, combinational.

Function
REQ-022 Classification: singles = sgl flag; command = cmd flag & ~sgl flag; timetag = ~sgl & ~cmd. Data = singles or timetag.
REQ-023 Command words: in_ready[i] = ~cmd_valid[i].
REQ-024 On a command handshake, cmd_data[i] <= word[CMD_LEN-1:0] and cmd_valid[i] <= 1.
REQ-025 cmd_valid[i] clears on cmd_valid & cmd_ready unless a new command word is accepted the same cycle; a same-cycle refill keeps it at 1.
REQ-026 Data words: output register is free when ~out_valid | out_ready.
REQ-027 Exactly one data requester is granted per cycle: the lowest index at or cyclically after pointer rr_ptr. in_ready[i] = grant[i] & free.
REQ-028 A granted data word appears on out_data/out_chan with out_valid = 1 the next cycle (latency 1); with out_ready held at 1, throughput is 1 word/clk.
REQ-029 After a data handshake on channel g, rr_ptr <= (g+1) mod NCH. With no handshake, rr_ptr holds.
REQ-030 out_data, out_chan and out_valid hold stable while out_valid & ~out_ready.
REQ-031 Head-of-line blocking is accepted: a channel whose head word is blocked does not stall other channels.
REQ-032 Counters: 3 per channel. Each increments by 1 on an accepted input of its type and saturates at 2^CNT_WIDTH-1 (no wrap).
REQ-033 cnt_load bit k set clears counter (cnt_chan, k). A load coinciding with an increment yields 0.
REQ-034 Back-pressure only: no word is dropped or duplicated under any combination of valid/ready.

Reset
REQ-035 While rst = 0: out_valid = 0, cmd_valid = 0, in_ready = 0, rr_ptr = 0, all counters = 0, out_data/out_chan/cmd_data = 0.
REQ-036 Reset mid-transfer discards registered words. The first grant after release goes to the lowest valid index from 0.

Structure
REQ-037 A shared package holds the flag offsets, the counter type encoding (SGL = 0, TT = 1, CMD = 2) and an event class enumeration.
REQ-038 One sub-module, rr_arbiter (parameter N; req, advance, grant one-hot, grant index), is instantiated once.

Verification
REQ-039 Arbitration order: all 4 channels hold timetag words continuously, out_ready = 1 -> out_chan sequence 0,1,2,3,0..., one word/clk, first out_valid 1 cycle after in_valid.
REQ-040 Stall: out_ready = 0 for 5 cycles while out_valid = 1 -> out_data stable, in_ready all 0, no loss. Release -> stream resumes with the next channel in rotation.
REQ-041 Command routing: channel 2 word with bit115 = 1, bit122 = 0, low bits 0xDEADBEEF -> cmd_valid[2] = 1, cmd_data[2] = 0xDEADBEEF, out_valid stays 0, cmd counter of channel 2 = 1.
REQ-042 Command back-pressure: cmd_ready[1] = 0 with two command words on channel 1 -> second word waits (in_ready[1] = 0) while channel 0 data flows uninterrupted.
REQ-043 Counter saturation and load: CNT_WIDTH = 4, 20 singles on channel 3 -> cnt_value = 15. A cnt_load pulse in the same cycle as an increment -> 0.
REQ-044 Reset: assert rst mid-stream -> all outputs 0 asynchronously. After release, channels 1 and 3 valid -> first grant to channel 1.
